// File: rtl/linkinit_sb_handshake_if.sv
// Sideband message bundle between the LINKINIT handshake engine (master) and
// the SB message layer / link partner (slave).
interface linkinit_sb_handshake_if #(
    parameter int MSG_W = 8
);
    logic [MSG_W-1:0] SB_TX_msg_o;
    logic [63:0]      SB_TX_dataBus_o;
    logic             SB_TX_msg_valid_o;
    logic             SB_TX_msg_sendNextFlag_i;
    logic [MSG_W-1:0] SB_RX_msg_i;
    logic [63:0]      SB_RX_dataBus_i;
    logic             SB_RX_msg_req_o;
    logic             SB_RX_msg_valid_i;

    modport master (
        output SB_TX_msg_o, SB_TX_dataBus_o, SB_TX_msg_valid_o, SB_RX_msg_req_o,
        input  SB_TX_msg_sendNextFlag_i, SB_RX_msg_i, SB_RX_dataBus_i, SB_RX_msg_valid_i
    );

    modport slave (
        input  SB_TX_msg_o, SB_TX_dataBus_o, SB_TX_msg_valid_o, SB_RX_msg_req_o,
        output SB_TX_msg_sendNextFlag_i, SB_RX_msg_i, SB_RX_dataBus_i, SB_RX_msg_valid_i
    );
endinterface

// File: rtl/linkinit_sb_handshake.sv
// Sideband request/response handshake engine for LINKINIT-class LTSM states:
// runs N_STEPS exchanges in order, each with its own timeout and retry budget.
module linkinit_sb_handshake #(
    parameter int N_STEPS        = 2,
    parameter int MSG_W          = 8,
    parameter int TIMEOUT_CYCLES = 8000,
    parameter int MAX_RETRY      = 3
) (
    input  logic                            clk_100MHz,
    input  logic                            reset,
    input  logic                            enable_i,
    input  logic [N_STEPS*MSG_W-1:0]        req_codes_i,
    input  logic [N_STEPS*MSG_W-1:0]        resp_codes_i,
    linkinit_sb_handshake_if.master         sb,
    output logic [$clog2(N_STEPS+1)-1:0]    step_o,
    output logic [$clog2(MAX_RETRY+1)-1:0]  retry_cnt_o,
    output logic                            done_o,
    output logic                            error_o,
    output logic                            reset_state_timeout_counter_o
);
    localparam int STEP_W  = $clog2(N_STEPS + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TX_REQ, S_WAIT, S_TX_RESP, S_TIMEOUT, S_STEP_DONE, S_DONE, S_ERROR
    } state_e;

    state_e               state_q, state_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 got_req_q, got_req_d;
    logic                 got_resp_q, got_resp_d;
    logic                 resp_sent_q, resp_sent_d;
    logic                 en_q;

    logic [MSG_W-1:0]     cur_req, cur_resp, tx_msg;
    logic                 tx_valid, rx_active, rx_fire, req_hit, resp_hit, tx_fire, en_edge;
    logic                 start_pulse;
    logic                 unused_rx_data;

    assign unused_rx_data = ^sb.SB_RX_dataBus_i;

    always_comb begin
        cur_req  = '0;
        cur_resp = '0;
        for (int k = 0; k < N_STEPS; k++) begin
            if (step_q == STEP_W'(k)) begin
                cur_req  = req_codes_i[k*MSG_W +: MSG_W];
                cur_resp = resp_codes_i[k*MSG_W +: MSG_W];
            end
        end
    end

    assign rx_active = (state_q == S_TX_REQ) || (state_q == S_WAIT) || (state_q == S_TX_RESP);
    assign tx_valid  = (state_q == S_TX_REQ) || (state_q == S_TX_RESP);
    assign tx_msg    = (state_q == S_TX_REQ)  ? cur_req  :
                       (state_q == S_TX_RESP) ? cur_resp : '0;
    assign tx_fire   = tx_valid && sb.SB_TX_msg_sendNextFlag_i;
    assign rx_fire   = rx_active && sb.SB_RX_msg_valid_i;
    // Unknown codes are still consumed, but count as neither hit nor progress.
    assign req_hit   = rx_fire && (sb.SB_RX_msg_i == cur_req);
    assign resp_hit  = rx_fire && (sb.SB_RX_msg_i == cur_resp);
    assign en_edge   = enable_i && !en_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d     = state_q;
        step_d      = step_q;
        retry_d     = retry_q;
        timer_d     = '0;
        got_req_d   = got_req_q   || req_hit;
        got_resp_d  = got_resp_q  || resp_hit;
        resp_sent_d = resp_sent_q;
        start_pulse = 1'b0;

        if (rx_active) begin
            if (tx_fire || req_hit || resp_hit) timer_d = '0;
            else if (timer_q != TIMER_MAX)      timer_d = timer_q + TIMER_W'(1);
            else                                timer_d = timer_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (en_edge) begin
                    start_pulse = 1'b1;
                    step_d      = '0;
                    retry_d     = '0;
                    got_req_d   = 1'b0;
                    got_resp_d  = 1'b0;
                    resp_sent_d = 1'b0;
                    state_d     = S_TX_REQ;
                end
            end
            S_TX_REQ:  if (tx_fire) state_d = S_WAIT;
            S_WAIT: begin
                if ((got_req_q || req_hit) && !resp_sent_q)            state_d = S_TX_RESP;
                else if (resp_sent_q && (got_resp_q || resp_hit))      state_d = S_STEP_DONE;
                else if (timer_q == TIMER_MAX)                         state_d = S_TIMEOUT;
            end
            S_TX_RESP: begin
                if (tx_fire) begin
                    resp_sent_d = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            S_TIMEOUT: begin
                if (!got_resp_q && (retry_q < RETRY_W'(MAX_RETRY))) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = S_TX_REQ;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_STEP_DONE: begin
                got_req_d   = 1'b0;
                got_resp_d  = 1'b0;
                resp_sent_d = 1'b0;
                retry_d     = '0;
                if (step_q == STEP_W'(N_STEPS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                    state_d = S_TX_REQ;
                end
            end
            S_DONE, S_ERROR: ;
            default: state_d = S_IDLE;
        endcase

        if (!enable_i) begin
            state_d     = S_IDLE;
            step_d      = '0;
            retry_d     = '0;
            timer_d     = '0;
            got_req_d   = 1'b0;
            got_resp_d  = 1'b0;
            resp_sent_d = 1'b0;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            retry_q     <= '0;
            timer_q     <= '0;
            got_req_q   <= 1'b0;
            got_resp_q  <= 1'b0;
            resp_sent_q <= 1'b0;
            // NOTE: held at 1 in reset so an enable already high at release is not taken as a new start edge.
            en_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            got_req_q   <= got_req_d;
            got_resp_q  <= got_resp_d;
            resp_sent_q <= resp_sent_d;
            en_q        <= enable_i;
        end
    end

    assign sb.SB_TX_msg_o       = tx_msg;
    assign sb.SB_TX_dataBus_o   = '0;
    assign sb.SB_TX_msg_valid_o = tx_valid;
    assign sb.SB_RX_msg_req_o   = rx_active;

    assign step_o      = step_q;
    assign retry_cnt_o = retry_q;
    assign done_o      = (state_q == S_DONE);
    assign error_o     = (state_q == S_ERROR);
    assign reset_state_timeout_counter_o = start_pulse || (state_q == S_STEP_DONE);
endmodule

// File: doc/linkinit_sb_handshake.md
Name: linkinit_sb_handshake

Overview:
- Parametrised sideband handshake engine for the LTSM LINKINIT-class states.
- Runs N_STEPS request/response message exchanges with the link partner, in order, over the SB message interface.
- Each exchange has its own timeout and bounded retry. Completion raises done; exhausted retries raise error, which the LTSM treats as a TRAINERROR trigger.
- Replaces hard-coded single-exchange state blocks. Message codes come from input ports, so LINKINIT, ACTIVE-entry and similar states reuse one instance.

Parameters:
- N_STEPS, 2, number of sequential req/resp exchanges (1..8).
- MSG_W, 8, width of an SB message code.
- TIMEOUT_CYCLES, 8000, clk_100MHz cycles without progress before a retry (80 us).
- MAX_RETRY, 3, request resends allowed per step before error.

Ports:
- clk_100MHz  in  1  sideband-domain clock.
- reset  in  1  synchronous, active-low reset.
- enable_i  in  1  start/hold. A rising edge starts step 0. Deassertion aborts to IDLE.
- req_codes_i  in  N_STEPS*MSG_W  request code per step; step k occupies bits [k*MSG_W +: MSG_W].
- resp_codes_i  in  N_STEPS*MSG_W  response code per step, same packing.
- SB_TX_msg_o  out  MSG_W  outgoing message code.
- SB_TX_dataBus_o  out  64  always 0.
- SB_TX_msg_valid_o  out  1  TX message valid.
- SB_TX_msg_sendNextFlag_i  in  1  TX accept.
- SB_RX_msg_i  in  MSG_W  incoming message code.
- SB_RX_dataBus_i  in  64  ignored.
- SB_RX_msg_req_o  out  1  ready to consume an RX message.
- SB_RX_msg_valid_i  in  1  RX message valid.
- step_o  out  $clog2(N_STEPS+1)  current step index.
- retry_cnt_o  out  $clog2(MAX_RETRY+1)  retries used in the current step.
- done_o  out  1  all steps complete.
- error_o  out  1  retries exhausted.
- reset_state_timeout_counter_o  out  1  one-cycle pulse at each step completion and at start.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE.
  - All outputs 0: SB_TX_msg_o=0, step_o=0, retry_cnt_o=0, done_o=0, error_o=0.
  - Internal flags got_req, got_resp, resp_sent and the timer cleared.
  - Reset mid-exchange drops any pending TX immediately; no partial handshake completes.
- TX handshake:
  - SB_TX_msg_o is held stable while SB_TX_msg_valid_o=1.
  - A transfer occurs in a cycle where valid==1 and sendNextFlag==1.
  - Valid is 0 in the following cycle.
- RX handshake:
  - A message is consumed in a cycle where SB_RX_msg_req_o==1 and SB_RX_msg_valid_i==1.
  - req_o=1 in TX_REQ, WAIT and TX_RESP; 0 otherwise.
- States:
  - IDLE:
    - Wait for an enable_i 0->1 edge.
    - Then pulse reset_state_timeout_counter_o, set step=0, clear flags and timer, go to TX_REQ.
  - TX_REQ:
    - Valid=1, msg=req_codes[step].
    - On transfer, go to WAIT.
  - WAIT:
    - On an RX consume: code==req_codes[step] sets got_req; code==resp_codes[step] sets got_resp; any other code is dropped with no effect.
    - Priority when several conditions hold in the same cycle, in this order:
      1. got_req (registered or arriving this cycle) and !resp_sent: go to TX_RESP.
      2. resp_sent and got_resp (either arriving this cycle): go to STEP_DONE.
      3. Timer==TIMEOUT_CYCLES-1: go to TIMEOUT.
  - TX_RESP:
    - Valid=1, msg=resp_codes[step]. RX consumption continues.
    - On transfer, set resp_sent and return to WAIT.
  - TIMEOUT (1 cycle):
    - If got_resp==0 and retry_cnt<MAX_RETRY: increment retry_cnt, clear timer, go to TX_REQ. got_req, resp_sent and got_resp are kept.
    - Otherwise set error_o=1 and go to ERROR.
  - STEP_DONE (1 cycle):
    - Pulse reset_state_timeout_counter_o; clear flags, timer and retry_cnt.
    - If step==N_STEPS-1, go to DONE; else increment step and go to TX_REQ.
  - DONE: done_o=1, hold.
  - ERROR: error_o=1, hold.
- Timer:
  - Counts +1 per cycle in TX_REQ, WAIT and TX_RESP.
  - Clears on any TX transfer or any matching RX consume (progress).
  - Saturates at TIMEOUT_CYCLES-1.
- Abort: enable_i==0 in any state moves to IDLE next cycle, clearing done_o, error_o, step, retry and all flags.
- Duplicate requests: a req_codes[step] message arriving after resp_sent=1 re-sets got_req only; no second response is sent.
- A late resp of a previous step is dropped because the codes differ.

Test Plan:
- N_STEPS=2, codes req={0x11,0x21}, resp={0x12,0x22}:
  - Partner sends the request one cycle after our request transfers, then the response; sendNextFlag is always 1.
  - Required: TX sequence 0x11,0x12,0x21,0x22; done_o=1; exactly 3 reset_state_timeout pulses.
- Partner's request and response arrive before our own request transfers (sendNextFlag held 0 for 20 cycles):
  - Required: after release, 0x11 then 0x12 are sent back-to-back; step advances; no retry.
- Partner silent, TIMEOUT_CYCLES=16, MAX_RETRY=3:
  - Required: 0x11 transmitted 4 times at 16-cycle spacing; retry_cnt_o reaches 3; error_o=1; done_o=0.
- Partner sends an unknown code 0x7F, then a valid exchange:
  - Required: 0x7F is consumed and ignored, the timer does not clear on it, and the step completes normally.
- enable_i deasserted while in TX_RESP of step 1:
  - Required: the next cycle is IDLE; valid=0; step_o=0.
  - Re-assertion of enable_i restarts the sequence from 0x11.
- reset=0 asserted during WAIT:
  - Required: all outputs 0 at the next edge.
  - After release with enable_i still high, no start until an enable 0->1 edge.
